// File: rtl/dpmem_pkg.sv
// dpmem_pkg: shared FSM encoding, read-latency limits and collision priority
package dpmem_pkg;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  localparam int RD_LAT_MAX = 2;
  localparam bit PORT1_WINS = 1'b1;
  function automatic bit lat_ok(int lat);
    return lat >= 1 && lat <= RD_LAT_MAX;
  endfunction
endpackage

// File: rtl/dpmem_rd_pipe.sv
// dpmem_rd_pipe: LAT-deep read return pipeline carrying data, valid and range error
module dpmem_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  logic              err,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] data_q,
  output logic              vld_q,
  output logic              err_q
);
  logic [LAT-1:0] v, e;
  logic [DATA_W-1:0] d [LAT];
  // data stages only load on a valid beat so the output holds between reads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      e <= '0;
      for (int i = 0; i < LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= vld;
      e[0] <= err;
      if (vld) d[0] <= data;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        e[i] <= e[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  assign data_q = d[LAT-1];
  assign vld_q = v[LAT-1];
  assign err_q = e[LAT-1];
endmodule

// File: rtl/dual_port_mem_ctrl.sv
// dual_port_mem_ctrl: true dual-port RAM with post-reset clear, collision counting and range checks.
// Define DPMEM_READ_FWD_EN to forward a cross-port write to a same-cycle read.
module dual_port_mem_ctrl
  import dpmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 1024,
  parameter int READ_LAT = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter int CNT_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] DataIn_1,
  input  logic [ADDR_W-1:0] Address_1,
  input  logic              WriteEna_1,
  input  logic              ReadEna_1,
  output logic [DATA_W-1:0] DataOut_1,
  output logic              DataValid_1,
  output logic              RangeErr_1,
  input  logic [DATA_W-1:0] DataIn_2,
  input  logic [ADDR_W-1:0] Address_2,
  input  logic              WriteEna_2,
  input  logic              ReadEna_2,
  output logic [DATA_W-1:0] DataOut_2,
  output logic              DataValid_2,
  output logic              RangeErr_2,
  output logic              Ready,
  output logic              Collision,
  output logic [CNT_W-1:0]  CollisionCount
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  if (!lat_ok(READ_LAT)) begin : g_bad_lat
    $error("READ_LAT must be 1 or 2");
  end
  logic [0:0] state;
  logic [AW-1:0] clr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic ok1, ok2, we1, we2, re1, re2, same, coll, wr_err_1, wr_err_2, err_q1, err_q2;
  logic [AW-1:0] i1, i2;
  logic [DATA_W-1:0] rd1, rd2;
  assign Ready = state == ST_RUN;
  assign ok1 = {1'b0, Address_1} < LIM;
  assign ok2 = {1'b0, Address_2} < LIM;
  assign we1 = Ready & WriteEna_1 & ok1;
  assign we2 = Ready & WriteEna_2 & ok2;
  assign re1 = Ready & ReadEna_1;
  assign re2 = Ready & ReadEna_2;
  assign i1 = Address_1[AW-1:0];
  assign i2 = Address_2[AW-1:0];
  assign same = Address_1 == Address_2;
  assign coll = we1 & we2 & same;
`ifdef DPMEM_READ_FWD_EN
  assign rd1 = (we2 && !we1 && same) ? DataIn_2 : mem[i1];
  assign rd2 = (we1 && same) ? DataIn_1 : mem[i2];
`else
  assign rd1 = mem[i1];
  assign rd2 = mem[i2];
`endif
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= ST_INIT;
      clr <= '0;
      Collision <= 1'b0;
      CollisionCount <= '0;
      wr_err_1 <= 1'b0;
      wr_err_2 <= 1'b0;
    end else begin
      if (state == ST_INIT) begin
        clr <= clr + 1'b1;
        if (clr == LAST) state <= ST_RUN;
      end
      Collision <= coll;
      if (coll && CollisionCount != '1) CollisionCount <= CollisionCount + 1'b1;
      wr_err_1 <= Ready & WriteEna_1 & ~ReadEna_1 & ~ok1;
      wr_err_2 <= Ready & WriteEna_2 & ~ReadEna_2 & ~ok2;
    end
  // later assignment wins, so the priority port is written last
  always_ff @(posedge CLK)
    if (state == ST_INIT) mem[clr] <= INIT_VALUE;
    else begin
      if (we2 && !(coll && PORT1_WINS)) mem[i2] <= DataIn_2;
      if (we1 && !(coll && !PORT1_WINS)) mem[i1] <= DataIn_1;
    end
  dpmem_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LAT)) u_pipe_1 (
    .clk(CLK), .rst_n(RST_N), .vld(re1), .err(re1 & ~ok1), .data(ok1 ? rd1 : '0),
    .data_q(DataOut_1), .vld_q(DataValid_1), .err_q(err_q1)
  );
  dpmem_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LAT)) u_pipe_2 (
    .clk(CLK), .rst_n(RST_N), .vld(re2), .err(re2 & ~ok2), .data(ok2 ? rd2 : '0),
    .data_q(DataOut_2), .vld_q(DataValid_2), .err_q(err_q2)
  );
  assign RangeErr_1 = err_q1 | wr_err_1;
  assign RangeErr_2 = err_q2 | wr_err_2;
endmodule
